// File: rtl/drp_rr_sel.sv
// Round-robin picker: chooses the first pending port after last_grant,
// wrapping around, so the most recently served port has lowest priority.
module drp_rr_sel #(
    parameter int PORTS = 2,
    parameter int IW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] pending,
    input  logic [IW-1:0]    last_grant,
    output logic             grant_valid,
    output logic [IW-1:0]    grant_idx
);

    always_comb begin
        // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Scan from the farthest offset down so the nearest candidate is written last and wins.
        for (int k = PORTS; k >= 1; k--) begin
            if (pending[(int'(last_grant) + k) % PORTS]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'((int'(last_grant) + k) % PORTS);
            end
        end
    end

endmodule

// File: rtl/drp_arb.sv
// Multi-master DRP arbiter: latches one request per upstream port and issues
// them one at a time to a single transceiver DRP port, with a response timeout.
module drp_arb #(
    parameter int PORTS      = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1024,
    localparam int DW        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*ADDR_WIDTH-1:0] s_drp_addr,
    input  logic [PORTS*DW-1:0]         s_drp_do,
    output logic [PORTS*DW-1:0]         s_drp_di,
    input  logic [PORTS-1:0]            s_drp_en,
    input  logic [PORTS-1:0]            s_drp_we,
    output logic [PORTS-1:0]            s_drp_rdy,
    output logic [ADDR_WIDTH-1:0]       m_drp_addr,
    output logic [DW-1:0]               m_drp_do,
    input  logic [DW-1:0]               m_drp_di,
    output logic                        m_drp_en,
    output logic                        m_drp_we,
    input  logic                        m_drp_rdy,
    output logic                        timeout_err,
    output logic [PORTS-1:0]            overrun_err
);

    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [IW-1:0]           grant;
    logic [IW-1:0]           last_grant;
    logic [TW-1:0]           timer;
    logic [PORTS-1:0]        pending;
    logic [ADDR_WIDTH-1:0]   req_addr [PORTS];
    logic [DW-1:0]           req_data [PORTS];
    logic [PORTS-1:0]        req_we;
    logic                    sel_valid;
    logic [IW-1:0]           sel_idx;

    drp_rr_sel #(.PORTS(PORTS), .IW(IW)) u_rr_sel (
        .pending     (pending),
        .last_grant  (last_grant),
        .grant_valid (sel_valid),
        .grant_idx   (sel_idx)
    );

    // NOTE: the request latches have no reset; pending qualifies them, so stale contents are never issued.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (s_drp_en[i] && !pending[i]) begin
                req_addr[i] <= s_drp_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                req_data[i] <= s_drp_do[i*DW +: DW];
                req_we[i]   <= s_drp_we[i];
            end
        end
    end

    // A strobe on a port that still has a request outstanding is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            overrun_err <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                overrun_err[i] <= s_drp_en[i] && pending[i];
                if (state == RESP && grant == IW'(i)) begin
                    pending[i] <= 1'b0;
                end else if (s_drp_en[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= IW'(PORTS - 1);
            timer       <= '0;
            m_drp_addr  <= '0;
            m_drp_do    <= '0;
            m_drp_en    <= 1'b0;
            m_drp_we    <= 1'b0;
            s_drp_di    <= '0;
            s_drp_rdy   <= '0;
            timeout_err <= 1'b0;
        end else begin
            m_drp_en    <= 1'b0;
            m_drp_we    <= 1'b0;
            s_drp_rdy   <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant      <= sel_idx;
                        m_drp_addr <= req_addr[sel_idx];
                        m_drp_do   <= req_data[sel_idx];
                        m_drp_we   <= req_we[sel_idx];
                        m_drp_en   <= 1'b1;
                        timer      <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                    if (m_drp_rdy) begin
                        s_drp_di[grant*DW +: DW] <= m_drp_di;
                        state                    <= RESP;
                    end else if (TIMEOUT != 0 && timer == TW'(TIMEOUT)) begin
                        s_drp_di[grant*DW +: DW] <= '0;
                        timeout_err              <= 1'b1;
                        state                    <= RESP;
                    end
                end
                RESP: begin
                    s_drp_rdy[grant] <= 1'b1;
                    last_grant       <= grant;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
